// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address from the fetch unit, ack/data back from memory.
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// NanoRisc fetch/issue stage: PC, instruction register and FETCH/ISSUE/HALT sequencing.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    output logic [2:0]          opcode,
    output logic [INSTR_W-4:0]  operand,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                pc_write,
    input  logic                is_branch,
    input  logic                branch_taken,
    input  logic [PC_W-1:0]     branch_target,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                fetch_error
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] ir_reg, ir_next;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("instr_fetch_unit: TIMEOUT must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             error_reg, error_next;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            ir_reg       <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            ir_reg       <= ir_next;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_reg <= wait_cnt_next;
            error_reg    <= error_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        ir_next       = ir_reg;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
        error_next    = error_reg;
`endif
        case (state_reg)
            FETCH: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (imem.imem_ack) begin
                    ir_next    = imem.imem_data;
                    state_next = ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_reg == CNT_LAST) begin
                    error_next = 1'b1;
                    state_next = HALT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
`endif
            end
            ISSUE: begin
                if (exec_done) begin
                    if (!pc_write) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                        if (is_branch && branch_taken) begin
                            pc_next = branch_target;
                        end else begin
                            pc_next = pc_reg + 1'b1;
                        end
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_next = '0;
`endif
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // The state register sits at FETCH during reset, so the request is masked explicitly.
    assign imem.imem_req  = (state_reg == FETCH) && !reset;
    assign imem.imem_addr = pc_reg;
    assign instr_valid    = (state_reg == ISSUE);
    assign halted         = (state_reg == HALT);
    assign pc             = pc_reg;
    assign opcode         = ir_reg[INSTR_W-1 -: 3];
    assign operand        = ir_reg[INSTR_W-4:0];

`ifdef FETCH_TIMEOUT_EN
    assign fetch_error = error_reg;
`else
    assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus randomized instructions vs a behavioural model.
module tb_instr_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       exec_done = 1'b0;
    logic       pc_write = 1'b0;
    logic       is_branch = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       instr_valid;
    logic [7:0] pc;
    logic       halted;
    logic       fetch_error;

    instr_fetch_unit_if #(.PC_W(8), .INSTR_W(8)) imem ();

    instr_fetch_unit #(
        .PC_W(8), .INSTR_W(8), .RESET_PC(8'h00), .TIMEOUT(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .imem(imem),
        .opcode(opcode),
        .operand(operand),
        .instr_valid(instr_valid),
        .exec_done(exec_done),
        .pc_write(pc_write),
        .is_branch(is_branch),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .halted(halted),
        .fetch_error(fetch_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Behavioural model: PC, last fetched word, error flag, and what the stage is doing
    // (0 = waiting for an instruction, 1 = executing, 2 = halted, 3 = held in reset).
    logic [7:0] model_pc  = 8'h00;
    logic [7:0] model_ir  = 8'h00;
    logic       model_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int phase);
        check({tag, ".pc"},          32'(pc),               32'(model_pc));
        check({tag, ".imem_addr"},   32'(imem.imem_addr),   32'(model_pc));
        check({tag, ".imem_req"},    32'(imem.imem_req),    32'(phase == 0));
        check({tag, ".instr_valid"}, 32'(instr_valid),      32'(phase == 1));
        check({tag, ".halted"},      32'(halted),           32'(phase == 2));
        check({tag, ".opcode"},      32'(opcode),           32'(model_ir[7:5]));
        check({tag, ".operand"},     32'(operand),          32'(model_ir[4:0]));
        check({tag, ".fetch_error"}, 32'(fetch_error),      32'(model_err));
    endtask

    task automatic run_instr(input int ack_dly, input logic [7:0] data, input int exec_dly,
                             input bit pw, input bit br, input bit tk, input logic [7:0] tgt);
        $display("instr pc=%02h data=%02h ack_dly=%0d exec_dly=%0d pw=%0d br=%0d tk=%0d tgt=%02h",
                 model_pc, data, ack_dly, exec_dly, pw, br, tk, tgt);
        check_all("fetch", 0);
        // exec_done toggles during FETCH must be ignored even with pc_write=0.
        exec_done = 1'($urandom);
        pc_write  = 1'b0;
        repeat (ack_dly) begin
            imem.imem_ack  = 1'b0;
            imem.imem_data = 8'($urandom);
            @(posedge clock); #1;
            check_all("ack_wait", 0);
        end
        imem.imem_ack  = 1'b1;
        imem.imem_data = data;
        @(posedge clock); #1;
        model_ir       = data;
        imem.imem_ack  = 1'b0;
        imem.imem_data = 8'($urandom);
        check_all("issue", 1);
        repeat (exec_dly) begin
            exec_done     = 1'b0;
            pc_write      = 1'($urandom);
            is_branch     = 1'($urandom);
            branch_taken  = 1'($urandom);
            branch_target = 8'($urandom);
            imem.imem_ack = 1'($urandom);
            @(posedge clock); #1;
            check_all("exec_wait", 1);
        end
        exec_done     = 1'b1;
        pc_write      = pw;
        is_branch     = br;
        branch_taken  = tk;
        branch_target = tgt;
        imem.imem_ack = 1'b0;
        @(posedge clock); #1;
        exec_done = 1'b0;
        pc_write  = 1'b0;
        if (pw) model_pc = (br && tk) ? tgt : 8'(model_pc + 8'd1);
        check_all("done", pw ? 0 : 2);
    endtask

    task automatic do_reset();
        imem.imem_ack = 1'b0;
        exec_done     = 1'b0;
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        model_pc  = 8'h00;
        model_ir  = 8'h00;
        model_err = 1'b0;
        $display("reset asserted mid-cycle");
        check_all("async_reset", 3);
        #1;
        reset = 1'b0;
        #1;
        check_all("after_reset", 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.imem_ack  = 1'b0;
        imem.imem_data = 8'h00;
        #1;
        check_all("power_on_reset", 3);
        @(posedge clock); @(posedge clock); #3;
        check_all("reset_held", 3);
        reset = 1'b0;
        #1;
        check_all("reset_release", 0);

        // Sequential instructions, delayed ack, and branches.
        run_instr(0, 8'h40, 0, 1, 0, 0, 8'h00);
        run_instr(0, 8'hE3, 0, 1, 0, 0, 8'h00);
        run_instr(3, 8'h5A, 0, 1, 0, 1, 8'h77);
        run_instr(0, 8'h21, 1, 1, 0, 0, 8'h00);
        run_instr(0, 8'h33, 0, 1, 0, 0, 8'h00);
        run_instr(0, 8'h99, 0, 1, 1, 1, 8'h10);
        run_instr(0, 8'h12, 2, 1, 1, 1, 8'h05);
        run_instr(0, 8'h87, 0, 1, 1, 0, 8'h10);

        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 2)),
                      1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Reset while a fetch is outstanding.
        imem.imem_ack = 1'b0;
        @(posedge clock); #1;
        check_all("fetch_pending", 0);
        do_reset();

        // PC wrap from 0xFF, then halt.
        run_instr(0, 8'hC1, 0, 1, 1, 1, 8'hFF);
        run_instr(1, 8'h64, 0, 1, 0, 0, 8'h00);
        run_instr(0, 8'h00, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            imem.imem_ack  = 1'b1;
            imem.imem_data = 8'($urandom);
            exec_done      = 1'b1;
            pc_write       = 1'b1;
            is_branch      = 1'b1;
            branch_taken   = 1'b1;
            branch_target  = 8'($urandom);
            @(posedge clock); #1;
            $display("halt cycle %0d", i);
            check_all("halt_sticky", 2);
        end
        exec_done = 1'b0;
        pc_write  = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            imem.imem_ack = 1'b0;
            @(posedge clock); #1;
            if (i == 15) model_err = 1'b1;
            $display("timeout wait cycle %0d", i);
            check_all("timeout", (i == 15) ? 2 : 0);
        end
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            imem.imem_ack = 1'b0;
            @(posedge clock); #1;
            check_all("late_ack_wait", 0);
        end
        imem.imem_ack  = 1'b1;
        imem.imem_data = 8'hA5;
        @(posedge clock); #1;
        imem.imem_ack = 1'b0;
        model_ir      = 8'hA5;
        $display("ack on final allowed cycle");
        check_all("late_ack", 1);
`else
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            imem.imem_ack = 1'b0;
            @(posedge clock); #1;
            $display("unbounded wait cycle %0d", i);
            check_all("no_timeout", 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
